// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared I2S definitions used by the receiver and transmitter.
//                Holds the default sample/slot sizes, the capture state
//                encoding and a helper for sizing the bit counter.
//  Revision    : 1.0  initial release
// ============================================================================
package i2s_pkg;

  // Default audio sample width (bits per channel).
  localparam int c_bitsize_default = 16;
  // Default slot length in sclk periods per channel.
  localparam int c_word_default    = 64;

  // Slot capture states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no slot boundary seen yet
    SHIFT = 2'd1,  // shifting in sample bits
    PAD   = 2'd2   // sample complete, ignoring slot padding
  } i2s_state_t;

  // Counter width able to hold the values 0..bits.
  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/i2s_lrclk_edge.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_lrclk_edge
//  Description : Registers word select and flags slot boundaries.
//  Ports       : sclk    - serial bit clock (posedge)
//                rst     - synchronous active-high reset
//                lrclk   - word select from the transmitter
//                lr_edge - high in the cycle lrclk differs from its
//                          registered copy (slot boundary)
//                lr_q    - registered word select = polarity of the slot
//                          currently being captured (0 left, 1 right)
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_lrclk_edge (
  input  logic sclk,
  input  logic rst,
  input  logic lrclk,
  output logic lr_edge,
  output logic lr_q
);

  logic r_lr_q;

  // The register tracks lrclk even while in reset, so the first cycle after
  // reset release never sees a spurious boundary.
  always_ff @(posedge sclk) begin
    r_lr_q <= lrclk;
  end

  assign lr_edge = !rst && (lrclk != r_lr_q);
  assign lr_q    = r_lr_q;

endmodule : i2s_lrclk_edge
`default_nettype wire

// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx
//  Description : I2S receiver. Captures BITSIZE bits MSB-first one sclk after
//                each word-select change, buffers the left sample and
//                publishes a left/right pair once the right sample of the
//                same frame completes. Short slots raise sync_err.
//  Ports       : sclk       - serial bit clock, all logic on posedge
//                rst        - synchronous active-high reset
//                lrclk      - word select (0 left, 1 right)
//                sdata      - serial data, MSB first
//                left_chan  - last complete left sample
//                right_chan - last complete right sample
//                valid      - one-cycle pulse when left/right_chan update
//                sync_err   - one-cycle pulse on a slot shorter than
//                             BITSIZE+1 sclk
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int BITSIZE = c_bitsize_default,
  parameter int WORD    = c_word_default
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               valid,
  output logic               sync_err
);

  localparam int                 c_cnt_w    = cnt_width(BITSIZE);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(BITSIZE - 1);
  localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(BITSIZE);
  localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

  // A slot must carry the delay bit plus every sample bit.
  if (BITSIZE < 2 || WORD < BITSIZE + 1) begin : g_param_check
    $error("i2s_rx: need BITSIZE >= 2 and WORD >= BITSIZE+1");
  end

  logic               w_lr_edge;
  logic               w_lr_q;
  logic [BITSIZE-1:0] w_word;

  i2s_state_t         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [BITSIZE-1:0] r_shift;
  logic [BITSIZE-1:0] r_hold;
  logic               r_left_done;

  i2s_lrclk_edge u_lrclk_edge (
    .sclk    (sclk),
    .rst     (rst),
    .lrclk   (lrclk),
    .lr_edge (w_lr_edge),
    .lr_q    (w_lr_q)
  );

  // Shift register contents including the bit arriving this cycle.
  assign w_word = {r_shift[BITSIZE-2:0], sdata};

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_left_done <= 1'b0;
      left_chan   <= '0;
      right_chan  <= '0;
      valid       <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      valid    <= 1'b0;
      sync_err <= 1'b0;

      if (w_lr_edge) begin
        // sdata this cycle is the last bit of the previous slot; capture
        // starts next cycle. A boundary in mid-capture means the slot was
        // too short: drop the partial word and any buffered left sample.
        if (r_state == SHIFT) begin
          sync_err    <= 1'b1;
          r_left_done <= 1'b0;
        end
        r_state <= SHIFT;
        r_cnt   <= '0;
        r_shift <= '0;
      end else begin
        case (r_state)
          SHIFT: begin
            r_shift <= w_word;
            if (r_cnt == c_last_bit) begin
              // Parked at BITSIZE in PAD; no wrap until the next boundary.
              r_cnt   <= c_full;
              r_state <= PAD;
              if (!w_lr_q) begin
                r_hold      <= w_word;
                r_left_done <= 1'b1;
              end else begin
                // A right sample only publishes when paired with a left
                // sample from the same frame.
                if (r_left_done) begin
                  left_chan  <= r_hold;
                  right_chan <= w_word;
                  valid      <= 1'b1;
                end
                r_left_done <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
          IDLE, PAD: begin
            // Wait for the next slot boundary.
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule : i2s_rx
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_rx
//  Description : Self-checking bench for i2s_rx. A negedge transmitter model
//                plays a table of frames into two receivers (WORD=64 and
//                WORD=17); every valid pulse is logged and compared against
//                the table, along with sync_err counts and pulse spacing.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2s_rx;

  localparam int BITSIZE = 16;

  logic        sclk = 1'b0;
  logic        rst;
  logic        lrclk;
  logic        sdata;
  logic [15:0] left64, right64, left17, right17;
  logic        valid64, valid17, serr64, serr17;

  always #5 sclk = ~sclk;

  i2s_rx #(.BITSIZE(BITSIZE), .WORD(64)) u_dut (
    .sclk       (sclk),
    .rst        (rst),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .left_chan  (left64),
    .right_chan (right64),
    .valid      (valid64),
    .sync_err   (serr64)
  );

  i2s_rx #(.BITSIZE(BITSIZE), .WORD(17)) u_dut17 (
    .sclk       (sclk),
    .rst        (rst),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .left_chan  (left17),
    .right_chan (right17),
    .valid      (valid17),
    .sync_err   (serr17)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          t;
  } obs_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          gap;   // expected cycles since previous valid, 0 = skip
  } exp_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          len_l;
    int          len_r;
    logic        pad;
    int          rst_l;     // left-slot index at which rst pulses, -1 none
    logic        exp_valid;
    int          gap;
  } frame_t;

  obs_t obs64[$];
  obs_t obs17[$];
  exp_t expq[$];
  int   err64 = 0;
  int   err17 = 0;

  always @(posedge sclk) cyc <= cyc + 1;

  // Monitor on the inactive edge.
  always @(negedge sclk) begin
    obs_t o;
    if (valid64) begin
      o.l = left64; o.r = right64; o.t = cyc;
      obs64.push_back(o);
    end
    if (valid17) begin
      o.l = left17; o.r = right17; o.t = cyc;
      obs17.push_back(o);
    end
    if (serr64) err64++;
    if (serr17) err17++;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One slot as a transmitter drives it on negedge: index 0 carries the
  // final bit of the previous slot, indices 1..16 the sample MSB first,
  // the rest padding.
  task automatic send_slot(input logic lr, input logic [15:0] data,
                           input int len, input logic pad, input int rst_at);
    for (int i = 0; i < len; i++) begin
      @(negedge sclk);
      if (rst_at >= 0 && i == rst_at + 1) begin
        rst = 1'b0;
        check("rst_pulse_out64", {left64, right64, valid64, serr64}, 64'h0);
        check("rst_pulse_out17", {left17, right17, valid17, serr17}, 64'h0);
      end
      lrclk = lr;
      if (i == 0)            sdata = pad;
      else if (i <= BITSIZE) sdata = data[BITSIZE - i];
      else                   sdata = pad;
      if (rst_at >= 0 && i == rst_at) rst = 1'b1;
    end
  endtask

  frame_t frames[11];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;

    frames[0]  = '{16'hA5C3, 16'h1234, 64, 64, 1'b0, -1, 1'b1, 0};
    frames[1]  = '{16'hA5C3, 16'h1234, 64, 64, 1'b1, -1, 1'b1, 128};
    frames[2]  = '{16'hFFFF, 16'h0000, 64, 64, 1'b1, -1, 1'b1, 128};
    frames[3]  = '{16'h8000, 16'h0001, 64, 64, 1'b1, -1, 1'b1, 128};
    frames[4]  = '{16'h7777, 16'h5555,  8, 64, 1'b0, -1, 1'b0, 0};   // short left
    frames[5]  = '{16'h1357, 16'h9BDF, 64, 64, 1'b1, -1, 1'b1, 200};
    frames[6]  = '{16'hDEAD, 16'hBEEF, 17, 17, 1'b1, -1, 1'b1, 81};
    frames[7]  = '{16'h0F0F, 16'hF0F0, 17, 17, 1'b0, -1, 1'b1, 34};
    frames[8]  = '{16'hC001, 16'h300C, 17, 17, 1'b1, -1, 1'b1, 34};
    frames[9]  = '{16'h4242, 16'h2424, 64, 64, 1'b0, 20, 1'b0, 0};   // rst mid-left
    frames[10] = '{16'h6789, 16'hABCD, 64, 64, 1'b1, -1, 1'b1, 0};

    // Reset held during a right slot.
    rst   = 1'b1;
    lrclk = 1'b1;
    sdata = 1'b0;
    repeat (5) @(negedge sclk);
    check("reset_left64",  left64,  16'h0);
    check("reset_right64", right64, 16'h0);
    check("reset_flags64", {valid64, serr64}, 2'b00);
    check("reset_left17",  left17,  16'h0);
    check("reset_right17", right17, 16'h0);
    check("reset_flags17", {valid17, serr17}, 2'b00);

    // Release mid right slot; remainder of that slot carries noise.
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sclk);
      sdata = 1'($urandom);
    end

    for (int f = 0; f < 11; f++) begin
      send_slot(1'b0, frames[f].l, frames[f].len_l, frames[f].pad, frames[f].rst_l);
      send_slot(1'b1, frames[f].r, frames[f].len_r, frames[f].pad, -1);
      if (frames[f].exp_valid) begin
        e.l = frames[f].l; e.r = frames[f].r; e.gap = frames[f].gap;
        expq.push_back(e);
      end
    end
    // Trailing slot lets the last right sample settle.
    send_slot(1'b0, 16'h0000, 20, 1'b0, -1);

    check("valid_count64", obs64.size(), expq.size());
    check("valid_count17", obs17.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < obs64.size()) begin
        check($sformatf("left64[%0d]", i),  obs64[i].l, expq[i].l);
        check($sformatf("right64[%0d]", i), obs64[i].r, expq[i].r);
        if (expq[i].gap > 0 && i > 0)
          check($sformatf("gap64[%0d]", i), obs64[i].t - obs64[i-1].t, expq[i].gap);
      end
      if (i < obs17.size()) begin
        check($sformatf("left17[%0d]", i),  obs17[i].l, expq[i].l);
        check($sformatf("right17[%0d]", i), obs17[i].r, expq[i].r);
        if (expq[i].gap > 0 && i > 0)
          check($sformatf("gap17[%0d]", i), obs17[i].t - obs17[i-1].t, expq[i].gap);
      end
    end
    check("sync_err_count64", err64, 1);
    check("sync_err_count17", err17, 1);
    check("hold_left64",  left64,  16'h6789);
    check("hold_right64", right64, 16'hABCD);
    check("hold_left17",  left17,  16'h6789);
    check("hold_right17", right17, 16'hABCD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_i2s_rx
`default_nettype wire

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter BITSIZE, default 16: audio sample width in bits per channel.
REQ-002 SHALL have parameter WORD, default 64: slot length in sclk periods per channel; BITSIZE+1 <= WORD is required.
REQ-003 SHALL have port sclk  input  1: serial bit clock; all logic on posedge sclk.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port lrclk  input  1: word select; 0 = left slot, 1 = right slot.
REQ-006 SHALL have port sdata  input  1: serial data, MSB first, driven by the transmitter on negedge sclk.
REQ-007 SHALL have port left_chan  output  BITSIZE: last complete left sample.
REQ-008 SHALL have port right_chan  output  BITSIZE: last complete right sample.
REQ-009 SHALL have port valid  output  1: one-sclk pulse when left_chan/right_chan update.
REQ-010 SHALL have port sync_err  output  1: one-sclk pulse on a slot shorter than BITSIZE+1 sclk.

Function
REQ-011 SHALL register lrclk into lr_q each posedge; an edge is detected at posedge k when lrclk != lr_q.
REQ-012 SHALL ignore sdata at edge-detect posedge k (last bit of previous slot, padding by REQ-002).
REQ-013 SHALL sample the MSB at posedge k+1 and the following BITSIZE-1 bits at posedges k+2 .. k+BITSIZE (I2S one-bit delay).
REQ-014 SHALL ignore all sdata after the BITSIZE-th bit until the next lrclk edge (slot padding).
REQ-015 SHALL use states IDLE, SHIFT, PAD: IDLE->SHIFT on lrclk edge; SHIFT->PAD after BITSIZE bits; PAD->SHIFT on lrclk edge; SHIFT->SHIFT on lrclk edge (resync, see REQ-019).
REQ-016 SHALL use a bit counter of width clog2(BITSIZE+1), cleared on every lrclk edge, with no wrap-around in PAD.
REQ-017 SHALL store a completed left slot (lr_q = 0 during capture) in an internal left holding register without changing outputs.
REQ-018 SHALL, at the posedge sampling the BITSIZE-th right bit with a left sample completed earlier in the same frame, load left_chan from the holding register and right_chan from the shift register, and drive valid = 1 for exactly that following cycle.
REQ-019 SHALL, on an lrclk edge while in SHIFT (fewer than BITSIZE bits captured): pulse sync_err for one cycle, discard the partial word, clear the left-complete flag, and begin capture of the new slot.
REQ-020 SHALL produce no valid for a right slot with no completed left slot in the same frame (startup mid-frame, or after REQ-019).
REQ-021 SHALL hold left_chan/right_chan stable between valid pulses.
REQ-022 SHALL count any WORD > BITSIZE as legal; a slot longer than WORD is not an error.

Reset
REQ-023 SHALL on rst = 1: state IDLE, counter 0, left_chan = 0, right_chan = 0, valid = 0, sync_err = 0, left-complete flag 0.
REQ-024 SHALL load lr_q <= lrclk during rst so that no false edge occurs on deassertion.
REQ-025 SHALL, on rst asserted mid-slot, abort capture; the first valid after reset follows a full left slot then a full right slot.

Structure
REQ-026 SHALL place the default BITSIZE/WORD constants and the state enum (IDLE, SHIFT, PAD) in shared package i2s_pkg, also used by i2s_tx.
REQ-027 SHALL implement the lrclk register/edge detect as sub-module i2s_lrclk_edge (outputs edge and the current slot polarity).

Verification
REQ-028 SHALL cover: BITSIZE=16, WORD=64, transmitter sends L=0xA5C3, R=0x1234 -> valid pulses once per frame, left_chan=0xA5C3, right_chan=0x1234.
REQ-029 SHALL cover: rst released while lrclk = 1 mid right slot -> no valid until one full left+right frame; first valid carries that frame's data.
REQ-030 SHALL cover: left slot truncated to 8 sclk -> sync_err pulses once, no valid that frame, next full frame gives correct data.
REQ-031 SHALL cover: L=0xFFFF, R=0x0000 then L=0x8000, R=0x0001 -> MSB/LSB alignment correct in each frame, with padding bits set to 1 ignored.
REQ-032 SHALL cover: rst pulsed one cycle mid-left slot -> outputs 0 the next cycle, no sync_err, recovery on the next frame.
REQ-033 SHALL cover: WORD=17 (minimum) back-to-back frames -> valid every 34 sclk, data correct.
